// File: rtl/sb_uart_resp.sv
// Soft 8N1 UART responder on the 8-bit system bus: TX/RX FIFOs, programmable divisor, level irq.
// Define SB_UART_LOOPBACK_EN to add the LOOP register (0x5) that routes TX back into RX.
module sb_uart_resp #(
  parameter logic [3:0]  BUS_ADDR74  = 4'b0011,
  parameter logic [15:0] DEFAULT_DIV = 16'd207,
  parameter int          FIFO_DEPTH  = 4
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       sb_stbi,
  input  logic       sb_rwi,
  input  logic [7:0] sb_adri,
  input  logic [7:0] sb_dati,
  output logic [7:0] sb_dato,
  output logic       sb_acko,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       irq
);

  localparam int PW = $clog2(FIFO_DEPTH);
  localparam logic [PW:0] FULL_LEVEL = (PW+1)'(FIFO_DEPTH);

  typedef enum logic [1:0] {TX_IDLE, TX_START, TX_DATA, TX_STOP} tx_state_t;
  typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

  logic        done, sel, wr, rd;
  logic [3:0]  reg_adr;
  logic [7:0]  rdata;
  logic [15:0] divisor;
  logic [1:0]  irq_en;
  logic        rx_ovr, fe, tx_ovr;
  logic        loop_en;

  logic [7:0]  tx_mem [FIFO_DEPTH];
  logic [PW-1:0] tx_wp, tx_rp;
  logic [PW:0] tx_level;
  logic        tx_full, tx_empty, tx_push, tx_load, tx_idle;

  logic [7:0]  rx_mem [FIFO_DEPTH];
  logic [PW-1:0] rx_wp, rx_rp;
  logic [PW:0] rx_level;
  logic        rx_full, rx_empty, rx_pop, rx_push, rx_ovr_set;

  tx_state_t   tx_state, tx_next;
  logic [15:0] tx_tick, tx_div;
  logic [2:0]  tx_bitn;
  logic [7:0]  tx_shift;
  logic        tx_tick_end, tx_bit, tx_ser;

  rx_state_t   rx_state, rx_next;
  logic [15:0] rx_tick, rx_div, rx_half, rx_mid;
  logic [2:0]  rx_bitn;
  logic [7:0]  rx_shift;
  logic        rx_in, rx_s1, rx_s2, rx_prev, rx_fall, rx_bit_hit, rx_start_hit;
  logic        rx_done, rx_fe_set;

  assign reg_adr = sb_adri[3:0];
  assign sel     = sb_stbi && (sb_adri[7:4] == BUS_ADDR74) && !done;
  assign wr      = sel && sb_rwi;
  assign rd      = sel && !sb_rwi;

  assign tx_full    = (tx_level == FULL_LEVEL);
  assign tx_empty   = (tx_level == '0);
  assign tx_push    = wr && (reg_adr == 4'h0) && !tx_full;
  assign tx_idle    = tx_empty && (tx_state == TX_IDLE);

  assign rx_full    = (rx_level == FULL_LEVEL);
  assign rx_empty   = (rx_level == '0);
  assign rx_pop     = rd && (reg_adr == 4'h0) && !rx_empty;
  // A same-cycle bus pop frees the slot the incoming byte needs.
  assign rx_push    = rx_done && (!rx_full || rx_pop);
  assign rx_ovr_set = rx_done && rx_full && !rx_pop;

`ifdef SB_UART_LOOPBACK_EN
  assign rx_in   = loop_en ? tx_ser : uart_rx;
  assign uart_tx = loop_en ? 1'b1 : tx_ser;
`else
  assign loop_en = 1'b0;
  assign rx_in   = uart_rx;
  assign uart_tx = tx_ser;
`endif

  always_comb begin
    rdata = 8'h00;
    case (reg_adr)
      4'h0: rdata = rx_empty ? 8'h00 : rx_mem[rx_rp];
      4'h1: rdata = {2'b00, tx_ovr, fe, rx_ovr, tx_idle, !tx_full, !rx_empty};
      4'h2: rdata = divisor[7:0];
      4'h3: rdata = divisor[15:8];
      4'h4: rdata = {6'b0, irq_en};
`ifdef SB_UART_LOOPBACK_EN
      4'h5: rdata = {7'b0, loop_en};
`endif
      default: rdata = 8'h00;
    endcase
  end

  // Bus handshake: done blocks a second ack until the strobe is released.
  always_ff @(posedge clk) begin
    if (rst) begin
      done    <= 1'b0;
      sb_acko <= 1'b0;
      sb_dato <= 8'h00;
    end else begin
      if (!sb_stbi)
        done <= 1'b0;
      else if (sel)
        done <= 1'b1;
      sb_acko <= sel;
      sb_dato <= rd ? rdata : 8'h00;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      divisor <= DEFAULT_DIV;
      irq_en  <= 2'b00;
      rx_ovr  <= 1'b0;
      fe      <= 1'b0;
      tx_ovr  <= 1'b0;
      irq     <= 1'b0;
    end else begin
      if (wr && reg_adr == 4'h2) divisor[7:0]  <= sb_dati;
      if (wr && reg_adr == 4'h3) divisor[15:8] <= sb_dati;
      if (wr && reg_adr == 4'h4) irq_en        <= sb_dati[1:0];
      rx_ovr <= rx_ovr_set | (rx_ovr & ~(wr && reg_adr == 4'h1 && sb_dati[3]));
      fe     <= rx_fe_set  | (fe     & ~(wr && reg_adr == 4'h1 && sb_dati[4]));
      tx_ovr <= (wr && reg_adr == 4'h0 && tx_full)
              | (tx_ovr & ~(wr && reg_adr == 4'h1 && sb_dati[5]));
      irq    <= (irq_en[0] & !rx_empty) | (irq_en[1] & tx_idle);
    end
  end

`ifdef SB_UART_LOOPBACK_EN
  always_ff @(posedge clk) begin
    if (rst)
      loop_en <= 1'b0;
    else if (wr && reg_adr == 4'h5)
      loop_en <= sb_dati[0];
  end
`endif

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp] <= sb_dati;
    if (rx_push) rx_mem[rx_wp] <= rx_shift;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_wp <= '0; tx_rp <= '0; tx_level <= '0;
      rx_wp <= '0; rx_rp <= '0; rx_level <= '0;
    end else begin
      if (tx_push) tx_wp <= tx_wp + 1'b1;
      if (tx_load) tx_rp <= tx_rp + 1'b1;
      tx_level <= tx_level + (PW+1)'(tx_push) - (PW+1)'(tx_load);
      if (rx_push) rx_wp <= rx_wp + 1'b1;
      if (rx_pop)  rx_rp <= rx_rp + 1'b1;
      rx_level <= rx_level + (PW+1)'(rx_push) - (PW+1)'(rx_pop);
    end
  end

  // TX: a byte is popped on entry to every START so frames run back to back.
  assign tx_tick_end = (tx_tick == tx_div);
  assign tx_load = !tx_empty &&
                   ((tx_state == TX_IDLE) || (tx_state == TX_STOP && tx_tick_end));

  always_ff @(posedge clk) begin
    if (rst) tx_state <= TX_IDLE;
    else     tx_state <= tx_next;
  end

  always_comb begin
    tx_next = tx_state;
    case (tx_state)
      TX_IDLE:  if (!tx_empty) tx_next = TX_START;
      TX_START: if (tx_tick_end) tx_next = TX_DATA;
      TX_DATA:  if (tx_tick_end && tx_bitn == 3'd7) tx_next = TX_STOP;
      TX_STOP:  if (tx_tick_end) tx_next = tx_empty ? TX_IDLE : TX_START;
      default:  tx_next = TX_IDLE;
    endcase
  end

  always_comb begin
    tx_bit = 1'b1;
    case (tx_state)
      TX_START: tx_bit = 1'b0;
      TX_DATA:  tx_bit = tx_shift[0];
      default:  tx_bit = 1'b1;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      tx_tick  <= '0;
      tx_div   <= DEFAULT_DIV;
      tx_bitn  <= '0;
      tx_shift <= '0;
      tx_ser   <= 1'b1;
    end else begin
      tx_ser <= tx_bit;
      if (tx_load) begin
        tx_tick  <= '0;
        tx_div   <= divisor;
        tx_bitn  <= '0;
        tx_shift <= tx_mem[tx_rp];
      end else if (tx_state != TX_IDLE) begin
        if (tx_tick_end) begin
          tx_tick <= '0;
          if (tx_state == TX_DATA) begin
            tx_shift <= {1'b0, tx_shift[7:1]};
            tx_bitn  <= tx_bitn + 3'd1;
          end
        end else begin
          tx_tick <= tx_tick + 16'd1;
        end
      end
    end
  end

  // RX: start bit is checked at its middle, then every bit is sampled one bit time later.
  assign rx_half      = (rx_div >> 1) + {15'b0, rx_div[0]};
  assign rx_mid       = (rx_half == 16'd0) ? 16'd0 : rx_half - 16'd1;
  assign rx_fall      = rx_prev && !rx_s2;
  assign rx_bit_hit   = (rx_tick == rx_div);
  assign rx_start_hit = (rx_tick == rx_mid);

  always_ff @(posedge clk) begin
    if (rst) rx_state <= RX_IDLE;
    else     rx_state <= rx_next;
  end

  always_comb begin
    rx_next = rx_state;
    case (rx_state)
      RX_IDLE:  if (rx_fall) rx_next = RX_START;
      RX_START: if (rx_start_hit) rx_next = rx_s2 ? RX_IDLE : RX_DATA;
      RX_DATA:  if (rx_bit_hit && rx_bitn == 3'd7) rx_next = RX_STOP;
      RX_STOP:  if (rx_bit_hit) rx_next = RX_IDLE;
      default:  rx_next = RX_IDLE;
    endcase
  end

  always_comb begin
    rx_done   = 1'b0;
    rx_fe_set = 1'b0;
    if (rx_state == RX_STOP && rx_bit_hit) begin
      rx_done   = 1'b1;
      rx_fe_set = !rx_s2;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rx_s1    <= 1'b1;
      rx_s2    <= 1'b1;
      rx_prev  <= 1'b1;
      rx_tick  <= '0;
      rx_div   <= DEFAULT_DIV;
      rx_bitn  <= '0;
      rx_shift <= '0;
    end else begin
      rx_s1   <= rx_in;
      rx_s2   <= rx_s1;
      rx_prev <= rx_s2;
      case (rx_state)
        RX_IDLE: begin
          rx_tick <= '0;
          if (rx_fall) rx_div <= divisor;
        end
        RX_START: begin
          rx_bitn <= '0;
          rx_tick <= rx_start_hit ? 16'd0 : rx_tick + 16'd1;
        end
        RX_DATA: begin
          if (rx_bit_hit) begin
            rx_tick  <= '0;
            rx_shift <= {rx_s2, rx_shift[7:1]};
            rx_bitn  <= rx_bitn + 3'd1;
          end else begin
            rx_tick <= rx_tick + 16'd1;
          end
        end
        default: rx_tick <= rx_tick + 16'd1;
      endcase
    end
  end

endmodule

// File: tb/tb_sb_uart_resp.sv
// Directed/randomized bench for sb_uart_resp: bus accesses, TX waveform, RX frames,
// FIFO overflow, strobe hold, glitch rejection and mid-frame reset.
module tb_sb_uart_resp;

  localparam int BIT = 4;

  logic       clk = 1'b0;
  logic       rst;
  logic       sb_stbi, sb_rwi;
  logic [7:0] sb_adri, sb_dati, sb_dato;
  logic       sb_acko;
  logic       uart_rx, uart_tx, irq;

  int n_checks = 0;
  int n_fail   = 0;

  logic       rec_on = 1'b0;
  logic       tx_samples[$];
  logic [7:0] tx_exp[$];
  logic [7:0] rx_model[$];
  logic       m_rxovr = 1'b0, m_fe = 1'b0, m_txovr = 1'b0;

  always #5 clk = ~clk;

  sb_uart_resp dut (
    .clk     (clk),
    .rst     (rst),
    .sb_stbi (sb_stbi),
    .sb_rwi  (sb_rwi),
    .sb_adri (sb_adri),
    .sb_dati (sb_dati),
    .sb_dato (sb_dato),
    .sb_acko (sb_acko),
    .uart_rx (uart_rx),
    .uart_tx (uart_tx),
    .irq     (irq)
  );

  // Serial line recorder, one sample per clock
  initial forever begin
    @(posedge clk);
    #1;
    if (rec_on) tx_samples.push_back(uart_tx);
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog expired");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  // One bus transaction, entered and left just after a rising edge
  task automatic applyStimulus(input logic rw, input logic [7:0] adr,
                               input logic [7:0] wdat, output logic [7:0] rdat);
    sb_stbi = 1'b1; sb_rwi = rw; sb_adri = adr; sb_dati = wdat;
    @(posedge clk); #1;
    checkOutput("ack_pulse", 32'(sb_acko), 1);
    rdat = sb_dato;
    if (rw) checkOutput("wr_dato_zero", 32'(sb_dato), 0);
    sb_stbi = 1'b0; sb_rwi = 1'b0; sb_adri = 8'h00; sb_dati = 8'h00;
    @(posedge clk); #1;
    checkOutput("ack_drop", 32'(sb_acko), 0);
    checkOutput("dato_idle", 32'(sb_dato), 0);
  endtask

  task automatic bus_write(input logic [7:0] adr, input logic [7:0] d);
    logic [7:0] unused_rd;
    applyStimulus(1'b1, adr, d, unused_rd);
  endtask

  task automatic read_check(input string tag, input logic [7:0] adr, input logic [7:0] exp);
    logic [7:0] d;
    applyStimulus(1'b0, adr, 8'h00, d);
    checkOutput(tag, 32'(d), 32'(exp));
  endtask

  task automatic read_data_check(input string tag);
    logic [7:0] exp;
    exp = (rx_model.size() != 0) ? rx_model.pop_front() : 8'h00;
    read_check(tag, 8'h30, exp);
  endtask

  function automatic logic [7:0] exp_status(input logic tx_idle, input logic tx_nfull);
    return {2'b00, m_txovr, m_fe, m_rxovr, tx_idle, tx_nfull, logic'(rx_model.size() != 0)};
  endfunction

  // Drive one 8N1 frame at BIT clocks per bit and update the receive model
  task automatic send_frame(input logic [7:0] d, input logic stop_bit);
    logic [9:0] frame;
    frame = {stop_bit, d, 1'b0};
    for (int i = 0; i < 10; i++) begin
      uart_rx = frame[i];
      repeat (BIT) begin @(posedge clk); #1; end
    end
    uart_rx = 1'b1;
    repeat (6) begin @(posedge clk); #1; end
    if (rx_model.size() < 4) rx_model.push_back(d);
    else m_rxovr = 1'b1;
    if (!stop_bit) m_fe = 1'b1;
  endtask

  task automatic start_rec();
    tx_samples.delete();
    rec_on = 1'b1;
  endtask

  // Compare the recorded line against back-to-back frames of tx_exp
  task automatic check_tx_wave(input string tag);
    int first, bad;
    logic e;
    rec_on = 1'b0;
    first = -1;
    bad = 0;
    for (int i = 0; i < tx_samples.size(); i++)
      if (first < 0 && tx_samples[i] == 1'b0) first = i;
    checkOutput({tag, "_frame_seen"}, 32'(first >= 0), 1);
    if (first >= 0) begin
      for (int i = first; i < tx_samples.size(); i++) begin
        int pos = (i - first) / BIT;
        int f = pos / 10;
        int b = pos % 10;
        if (f >= tx_exp.size()) e = 1'b1;
        else if (b == 0) e = 1'b0;
        else if (b == 9) e = 1'b1;
        else e = tx_exp[f][b-1];
        if (tx_samples[i] !== e) bad++;
      end
      checkOutput({tag, "_wave_errs"}, 32'(bad), 0);
      checkOutput({tag, "_long_enough"},
                  32'((tx_samples.size() - first) >= tx_exp.size() * 10 * BIT), 1);
    end
    tx_exp.delete();
  endtask

  initial begin
    logic [7:0] b;
    int acks, facks;

    rst = 1'b1; sb_stbi = 1'b0; sb_rwi = 1'b0; sb_adri = 8'h00; sb_dati = 8'h00;
    uart_rx = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    checkOutput("rst_uart_tx", 32'(uart_tx), 1);
    checkOutput("rst_irq", 32'(irq), 0);
    checkOutput("rst_ack", 32'(sb_acko), 0);
    checkOutput("rst_dato", 32'(sb_dato), 0);
    rst = 1'b0;

    read_check("status_reset", 8'h31, 8'h06);
    read_check("div_lo_reset", 8'h32, 8'hCF);
    read_check("div_hi_reset", 8'h33, 8'h00);
    read_check("irq_en_reset", 8'h34, 8'h00);
    bus_write(8'h32, 8'h03);
    bus_write(8'h33, 8'h00);
    read_check("div_lo_rw", 8'h32, 8'h03);
    read_check("unmapped_read", 8'h3F, 8'h00);

    // Single TX frame
    start_rec();
    tx_exp.push_back(8'hA5);
    bus_write(8'h30, 8'hA5);
    read_check("status_tx_busy", 8'h31, exp_status(1'b0, 1'b1));
    repeat (50) begin @(posedge clk); #1; end
    check_tx_wave("tx_a5");
    read_check("status_tx_done", 8'h31, exp_status(1'b1, 1'b1));

    // Back-to-back TX and TX overflow
    start_rec();
    for (int i = 0; i < 6; i++) begin
      b = 8'($urandom);
      if (i < 5) tx_exp.push_back(b);
      bus_write(8'h30, b);
    end
    m_txovr = 1'b1;
    read_check("status_tx_full", 8'h31, exp_status(1'b0, 1'b0));
    repeat (5 * 10 * BIT + 20) begin @(posedge clk); #1; end
    check_tx_wave("tx_burst");
    read_check("status_txovr", 8'h31, exp_status(1'b1, 1'b1));
    bus_write(8'h31, 8'h20);
    m_txovr = 1'b0;
    read_check("status_txovr_clr", 8'h31, exp_status(1'b1, 1'b1));

    // RX single frame with RX irq
    bus_write(8'h34, 8'h01);
    checkOutput("irq_rx_empty", 32'(irq), 0);
    send_frame(8'h3C, 1'b1);
    checkOutput("irq_rx_ready", 32'(irq), 1);
    read_check("status_rx_ready", 8'h31, exp_status(1'b1, 1'b1));
    read_data_check("rx_data_3c");
    read_data_check("rx_data_empty");
    read_check("status_rx_empty", 8'h31, exp_status(1'b1, 1'b1));
    checkOutput("irq_rx_drained", 32'(irq), 0);

    // RX overflow
    for (int i = 0; i < 5; i++) send_frame(8'($urandom), 1'b1);
    read_check("status_rxovr", 8'h31, exp_status(1'b1, 1'b1));
    for (int i = 0; i < 5; i++) read_data_check("rx_fifo_order");
    bus_write(8'h31, 8'h08);
    m_rxovr = 1'b0;
    read_check("status_rxovr_clr", 8'h31, exp_status(1'b1, 1'b1));

    // Held strobe and a foreign-slot strobe
    start_rec();
    b = 8'($urandom);
    tx_exp.push_back(b);
    acks = 0;
    sb_stbi = 1'b1; sb_rwi = 1'b1; sb_adri = 8'h30; sb_dati = b;
    repeat (6) begin @(posedge clk); #1; acks += int'(sb_acko); end
    sb_stbi = 1'b0;
    @(posedge clk); #1;
    facks = 0;
    sb_stbi = 1'b1; sb_rwi = 1'b1; sb_adri = 8'h00; sb_dati = ~b;
    repeat (3) begin @(posedge clk); #1; facks += int'(sb_acko); end
    sb_stbi = 1'b0; sb_adri = 8'h00;
    @(posedge clk); #1;
    checkOutput("held_strobe_acks", 32'(acks), 1);
    checkOutput("foreign_slot_acks", 32'(facks), 0);
    repeat (60) begin @(posedge clk); #1; end
    check_tx_wave("tx_held");

    // Glitch rejection, then a frame with a bad stop bit
    uart_rx = 1'b0;
    @(posedge clk); #1;
    uart_rx = 1'b1;
    repeat (12) begin @(posedge clk); #1; end
    read_check("status_glitch", 8'h31, exp_status(1'b1, 1'b1));
    send_frame(8'($urandom), 1'b0);
    read_check("status_fe", 8'h31, exp_status(1'b1, 1'b1));
    read_data_check("rx_data_fe");
    bus_write(8'h31, 8'h10);
    m_fe = 1'b0;
    read_check("status_fe_clr", 8'h31, exp_status(1'b1, 1'b1));

    // TX-idle irq, then reset in the middle of a frame
    bus_write(8'h34, 8'h02);
    checkOutput("irq_tx_idle", 32'(irq), 1);
    bus_write(8'h30, 8'($urandom));
    checkOutput("irq_tx_busy", 32'(irq), 0);
    repeat (10) begin @(posedge clk); #1; end
    rst = 1'b1;
    @(posedge clk); #1;
    checkOutput("midframe_rst_tx", 32'(uart_tx), 1);
    checkOutput("midframe_rst_irq", 32'(irq), 0);
    rst = 1'b0;
    read_check("div_lo_after_rst", 8'h32, 8'hCF);
    read_check("status_after_rst", 8'h31, 8'h06);

    $display("%0d/%0d checks passed", n_checks - n_fail, n_checks);
    $finish;
  end

endmodule
